// File: rtl/pcm_i2s_reader.sv
// pcm_i2s_reader: drains the stereo PCM RAM one frame ahead and serialises it as 16-bit stereo I2S,
// counting frames that had to be sent without data.
module pcm_i2s_reader #(
    parameter int AW = 10,
    parameter int BCLK_DIV = 4
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          ENABLE_I,
    input  logic [AW:0]   WR_PTR_I,
    output logic [AW:0]   RD_PTR_O,
    output logic [AW:0]   LEVEL_O,
    output logic          RAM_RE_O,
    output logic [AW-1:0] RAM_ADDR_O,
    input  logic [15:0]   CH0_DATA_I,
    input  logic [15:0]   CH1_DATA_I,
    output logic          I2S_BCLK_O,
    output logic          I2S_LRCK_O,
    output logic          I2S_SDATA_O,
    output logic          UNDERRUN_O,
    output logic [15:0]   UNDERRUN_CNT_O
);
    typedef enum logic [1:0] {EMPTY, ISSUE, CAPTURE, FULL} state_t;
    localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
    state_t state;
    logic [AW:0] rd_ptr;
    logic [31:0] hold, shift_reg, frame;
    logic [DW-1:0] div_cnt;
    logic [4:0] slot;
    logic bclk, ram_re, underrun, tick, fall, load, have;
    logic [15:0] underrun_cnt;
    assign tick = ENABLE_I && div_cnt == DW'(BCLK_DIV - 1);
    assign fall = tick && bclk;
    assign load = fall && slot == 5'd31;
    // a frame still in CAPTURE is bypassed straight from the RAM data lines
    assign have = state == FULL || state == CAPTURE;
    assign frame = state == FULL ? hold : {CH0_DATA_I, CH1_DATA_I};
    assign RD_PTR_O = rd_ptr;
    assign LEVEL_O = WR_PTR_I - rd_ptr;
    assign RAM_RE_O = ram_re;
    assign RAM_ADDR_O = rd_ptr[AW-1:0];
    assign I2S_BCLK_O = bclk;
    assign I2S_LRCK_O = (slot + 5'd1) >= 5'd16;
    assign I2S_SDATA_O = shift_reg[31];
    assign UNDERRUN_O = underrun;
    assign UNDERRUN_CNT_O = underrun_cnt;
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= EMPTY;
            rd_ptr <= '0;
            hold <= '0;
            shift_reg <= '0;
            div_cnt <= '0;
            slot <= 5'd31;
            bclk <= 1'b0;
            ram_re <= 1'b0;
            underrun <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= load && !have;
            if (load && !have && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
            ram_re <= state == EMPTY && ENABLE_I && LEVEL_O != '0;
            case (state)
                EMPTY: if (ENABLE_I && LEVEL_O != '0) state <= ISSUE;
                ISSUE: begin
                    state <= CAPTURE;
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
                CAPTURE: begin
                    hold <= {CH0_DATA_I, CH1_DATA_I};
                    state <= load ? EMPTY : FULL;
                end
                FULL: if (load) state <= EMPTY;
            endcase
            if (!ENABLE_I) begin
                div_cnt <= '0;
                bclk <= 1'b0;
                slot <= 5'd31;
                shift_reg <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                if (tick) bclk <= !bclk;
                if (fall) begin
                    slot <= slot + 5'd1;
                    shift_reg <= load ? (have ? frame : 32'h0) : {shift_reg[30:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_pcm_i2s_reader.sv
// tb_pcm_i2s_reader: random writer traffic scored against a frame-level playback model;
// an independent monitor deserialises I2S and pops expected frames.
module tb_pcm_i2s_reader;
    localparam int AW = 2;
    localparam int DIV = 2;
    localparam int FP = 64 * DIV;
    typedef struct packed {logic [31:0] word; logic ur;} exp_t;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [AW:0] wr_ptr = '0;
    logic [AW:0] rd_ptr, level;
    logic re, bclk, lrck, sd, ur;
    logic [AW-1:0] addr;
    logic [15:0] ch0, ch1, ur_cnt;
    logic [31:0] mem [4];
    exp_t exp_q[$];
    logic [31:0] fifo[$];
    int checks = 0, errors = 0, re_cnt = 0, written = 0;
    logic [15:0] model_ur = 16'h0;
    logic [31:0] sh = 32'h0;
    logic pb = 1'b0, pl = 1'b0, mval = 1'b0;
    int ur_seen = 0, bitpos = 0, cyc = 0, last_emit = 0;

    pcm_i2s_reader #(.AW(AW), .BCLK_DIV(DIV)) dut (
        .CLK_I(clk), .RST_I(rst), .ENABLE_I(en), .WR_PTR_I(wr_ptr),
        .RD_PTR_O(rd_ptr), .LEVEL_O(level), .RAM_RE_O(re), .RAM_ADDR_O(addr),
        .CH0_DATA_I(ch0), .CH1_DATA_I(ch1), .I2S_BCLK_O(bclk), .I2S_LRCK_O(lrck),
        .I2S_SDATA_O(sd), .UNDERRUN_O(ur), .UNDERRUN_CNT_O(ur_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (re) {ch0, ch1} <= mem[addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: samples at the falling system-clock edge, collects bits on BCLK rises
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (ur) ur_seen++;
            if (re) begin
                chk("ram_addr_seq", 32'(addr), 32'(re_cnt % 4));
                chk("ram_addr_ptr", 32'(addr), 32'(rd_ptr[AW-1:0]));
                re_cnt++;
            end
            if (bclk && !pb) begin
                sh = {sh[30:0], sd};
                if (pl && !lrck) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %h expected no frame", sh);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_word", sh, e.word);
                        chk("underrun_pulses", ur_seen, 32'(e.ur));
                        if (mval) begin
                            chk("frame_bits", bitpos, 31);
                            chk("frame_cycles", cyc - last_emit, FP);
                        end
                    end
                    ur_seen = 0;
                    bitpos = 0;
                    mval = 1'b1;
                    last_emit = cyc;
                end else if (mval) begin
                    chk("lrck_slot", 32'(lrck), 32'(bitpos >= 15));
                    bitpos++;
                end
                pl = lrck;
            end
            pb = bclk;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lrck(input logic v);
        logic p;
        for (int n = 0; n < 300; n++) begin
            p = lrck;
            step();
            if (lrck == v && p != v) return;
        end
        checks++;
        errors++;
        $display("FAIL lrck_timeout: no LRCK edge to %0b within 300 cycles", v);
    endtask

    task automatic write_frame(input logic [31:0] w);
        mem[wr_ptr[AW-1:0]] = w;
        wr_ptr = wr_ptr + 1'b1;
        written++;
        fifo.push_back(w);
    endtask

    // the next frame load plays the oldest unplayed frame, or silence with an underrun
    task automatic push_exp();
        exp_t e;
        if (fifo.size() > 0) begin
            e.word = fifo.pop_front();
            e.ur = 1'b0;
        end else begin
            e.word = 32'h0;
            e.ur = 1'b1;
            if (model_ur != 16'hFFFF) model_ur++;
        end
        exp_q.push_back(e);
    endtask

    // one frame is prefetched into the hold register, the rest wait in RAM
    task automatic checkpoint();
        int pend;
        pend = fifo.size() > 0 ? fifo.size() - 1 : 0;
        chk("underrun_cnt", 32'(ur_cnt), 32'(model_ur));
        chk("rd_ptr", 32'(rd_ptr), 32'((written - pend) % 8));
        chk("level", 32'(level), 32'(pend));
    endtask

    task automatic period(input int max_n);
        int n;
        wait_lrck(1'b1);
        checkpoint();
        n = $urandom_range(0, max_n);
        if (fifo.size() + n > 3) n = 3 - fifo.size();
        for (int i = 0; i < n; i++) write_frame($urandom());
        push_exp();
    endtask

    task automatic enable_and_time();
        int rise_at = 0, fall_at = 0;
        logic p;
        ur_seen = 0;
        mval = 1'b0;
        pl = 1'b0;
        en = 1'b1;
        for (int i = 1; i <= 4 * DIV && fall_at == 0; i++) begin
            p = bclk;
            step();
            if (bclk && !p && rise_at == 0) rise_at = i;
            if (!bclk && p) fall_at = i;
        end
        chk("bclk_first_rise", rise_at, DIV);
        chk("first_fall", fall_at, 2 * DIV);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_rd_ptr", 32'(rd_ptr), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_re", 32'(re), 0);
        chk("rst_bclk", 32'(bclk), 0);
        chk("rst_lrck", 32'(lrck), 0);
        chk("rst_sdata", 32'(sd), 0);
        chk("rst_underrun", 32'(ur), 0);
        chk("rst_ur_cnt", 32'(ur_cnt), 0);
        rst = 1'b0;
        step();
        // basic playback of a known frame
        write_frame(32'hA55A_1234);
        push_exp();
        enable_and_time();
        chk("basic_rd_ptr", 32'(rd_ptr), 1);
        chk("basic_level", 32'(level), 0);
        for (int i = 0; i < 12; i++) period(2);
        for (int i = 0; i < 3; i++) period(0);
        // frame published just late enough that CAPTURE meets the frame load
        wait_lrck(1'b1);
        checkpoint();
        wait_lrck(1'b0);
        step();
        write_frame($urandom());
        push_exp();
        for (int i = 0; i < 3; i++) period(2);
        // enable drop at slot 10 with a frame waiting in the hold register
        period(0);
        period(0);
        wait_lrck(1'b1);
        checkpoint();
        write_frame($urandom());
        write_frame($urandom());
        push_exp();
        wait_lrck(1'b0);
        repeat (4 + 10 * 4) step();
        en = 1'b0;
        step();
        chk("dis_bclk", 32'(bclk), 0);
        chk("dis_lrck", 32'(lrck), 0);
        chk("dis_sdata", 32'(sd), 0);
        exp_q.delete();
        mval = 1'b0;
        pl = 1'b0;
        repeat (5) step();
        chk("dis_rd_ptr", 32'(rd_ptr), 32'(written % 8));
        chk("dis_level", 32'(level), 0);
        push_exp();
        enable_and_time();
        for (int i = 0; i < 4; i++) period(2);
        // reset at slot 5
        wait_lrck(1'b0);
        repeat (4 + 5 * 4) step();
        rst = 1'b1;
        en = 1'b0;
        wr_ptr = '0;
        step();
        chk("mid_rst_rd_ptr", 32'(rd_ptr), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_re", 32'(re), 0);
        chk("mid_rst_bclk", 32'(bclk), 0);
        chk("mid_rst_lrck", 32'(lrck), 0);
        chk("mid_rst_sdata", 32'(sd), 0);
        chk("mid_rst_underrun", 32'(ur), 0);
        chk("mid_rst_ur_cnt", 32'(ur_cnt), 0);
        exp_q.delete();
        fifo.delete();
        written = 0;
        re_cnt = 0;
        model_ur = 16'h0;
        mval = 1'b0;
        pl = 1'b0;
        rst = 1'b0;
        step();
        // underrun counter saturation
        force dut.underrun_cnt = 16'hFFFE;
        step();
        release dut.underrun_cnt;
        step();
        model_ur = 16'hFFFE;
        chk("ur_cnt_preset", 32'(ur_cnt), 32'hFFFE);
        push_exp();
        enable_and_time();
        period(0);
        period(0);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) step();
        en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("final_ur_cnt", 32'(ur_cnt), 32'hFFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
